// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline stage with a two-entry skid buffer.
// Fetch sees a registered in_ready (no combinational path from out_ready),
// decode sees a stable main entry. Flush empties both entries and presents
// a NOP. A saturating counter records cycles where decode holds off a valid
// instruction.
module ifid_skid_stage #(
    parameter int             len       = 32,
    parameter logic [len-1:0] NOP_VALUE = {len{1'b0}},
    parameter int             CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [len-1:0]   pc,
    input  logic [len-1:0]   instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [len-1:0]   pc_out,
    output logic [len-1:0]   instruction_out,
    output logic [CNT_W-1:0] stall_cycles
);

    // State bits are {main_valid, skid_valid}; (0,1) cannot occur.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             main_valid;
    logic             skid_valid;
    logic             accept;
    logic             issue;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;
    logic [len-1:0]   main_pc_p1;
    logic [len-1:0]   main_instr_p1;
    logic [len-1:0]   skid_pc_p1;
    logic [len-1:0]   skid_instr_p1;
    logic [CNT_W-1:0] stall_cnt;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign main_valid      = state_q[1];
    assign skid_valid      = state_q[0];
    // in_ready depends only on the skid flop, never on out_ready.
    assign in_ready        = !skid_valid;
    assign out_valid       = main_valid;
    assign accept          = in_valid && in_ready;
    assign issue           = main_valid && out_ready;
    assign pc_out          = main_pc_p1;
    assign instruction_out = main_instr_p1;
    assign stall_cycles    = stall_cnt;

    // Occupancy state register; reset drops both entries immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy and which register loads; flush overrides everything.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_d      = BUSY;
                    end
                end
                BUSY: begin
                    if (accept && issue) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = FULL;
                    end else if (issue) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the skid can move up.
                    if (issue) begin
                        load_main_skid = 1'b1;
                        state_d        = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Main entry: drives decode; cleared to PC 0 / NOP on reset and flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            main_pc_p1    <= '0;
            main_instr_p1 <= NOP_VALUE;
        end else if (flush) begin
            main_pc_p1    <= '0;
            main_instr_p1 <= NOP_VALUE;
        end else if (load_main_in) begin
            main_pc_p1    <= pc;
            main_instr_p1 <= instruction;
        end else if (load_main_skid) begin
            main_pc_p1    <= skid_pc_p1;
            main_instr_p1 <= skid_instr_p1;
        end
    end

    // Skid entry data; its valid bit lives in state_q so no reset is needed.
    always_ff @(posedge clock) begin
        if (load_skid) begin
            skid_pc_p1    <= pc;
            skid_instr_p1 <= instruction;
        end
    end

    // Stall counter: counts held-off valid cycles, flush cycles included.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Testbench for ifid_skid_stage: directed scenarios plus a random
// valid/ready/flush regression against a queue-based reference model.
module tb_ifid_skid_stage;

    localparam int          LEN = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic [15:0] stall_cycles;

    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] pc_out4;
    logic [31:0] instruction_out4;
    logic [3:0]  stall_cycles4;

    int checks = 0;
    int errors = 0;

    // Reference model: the stage is a FIFO of at most two entries.
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_ins;
    logic [15:0] m_cnt;
    logic [3:0]  m_cnt4;

    ifid_skid_stage #(.len(LEN), .NOP_VALUE(NOP), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .instruction(instruction),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .instruction_out(instruction_out),
        .stall_cycles(stall_cycles)
    );

    ifid_skid_stage #(.len(LEN), .NOP_VALUE(NOP), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4),
        .pc(pc), .instruction(instruction),
        .out_valid(out_valid4), .out_ready(out_ready),
        .pc_out(pc_out4), .instruction_out(instruction_out4),
        .stall_cycles(stall_cycles4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        mq.delete();
        m_pc   = 32'h0;
        m_ins  = NOP;
        m_cnt  = 16'h0;
        m_cnt4 = 4'h0;
    endtask

    // Drive one cycle of inputs (just after an edge), advance one edge,
    // then update the model. Returns 1 ns after the edge.
    task automatic drive_cycle(input logic f, input logic iv, input logic [31:0] p,
                               input logic [31:0] ins, input logic ordy);
        bit acc;
        bit iss;
        flush       = f;
        in_valid    = iv;
        pc          = p;
        instruction = ins;
        out_ready   = ordy;
        acc = iv && (mq.size() < 2);
        iss = (mq.size() > 0) && ordy;
        if (mq.size() > 0 && !ordy) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt4 != 4'hF)    m_cnt4 = m_cnt4 + 4'd1;
        end
        @(posedge clock);
        #1;
        if (f) begin
            mq.delete();
            m_pc  = 32'h0;
            m_ins = NOP;
        end else begin
            if (iss) void'(mq.pop_front());
            if (acc) mq.push_back({p, ins});
            if (mq.size() > 0) {m_pc, m_ins} = mq[0];
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        pc = '0; instruction = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_flags got ov=%0b ir=%0b want ov=0 ir=1", out_valid, in_ready);
        end
        checks++;
        if ({pc_out, instruction_out} !== {32'h0, NOP}) begin
            errors++;
            $display("FAIL reset_data got pc=%h ins=%h want pc=0 ins=%h", pc_out, instruction_out, NOP);
        end
        checks++;
        if (stall_cycles !== 16'd0 || stall_cycles4 !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cycles, stall_cycles4);
        end
        reset = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc [3] = '{32'h100, 32'h104, 32'h108};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b1, exp_pc[i], 32'hA000_0000 + exp_pc[i], 1'b1);
            checks++;
            if ({out_valid, in_ready, pc_out, instruction_out} !==
                {1'b1, 1'b1, exp_pc[i], 32'hA000_0000 + exp_pc[i]}) begin
                errors++;
                $display("FAIL stream_%0d got ov=%0b ir=%0b pc=%h ins=%h want ov=1 ir=1 pc=%h ins=%h",
                         i, out_valid, in_ready, pc_out, instruction_out, exp_pc[i], 32'hA000_0000 + exp_pc[i]);
            end
        end
        drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if ({out_valid, pc_out, stall_cycles} !== {1'b0, 32'h108, 16'd0}) begin
            errors++;
            $display("FAIL stream_drain got ov=%0b pc=%h stall=%0d want ov=0 pc=108 stall=0",
                     out_valid, pc_out, stall_cycles);
        end
    endtask

    task automatic test_backpressure();
        drive_cycle(1'b0, 1'b1, 32'h100, 32'hB100, 1'b0);
        drive_cycle(1'b0, 1'b1, 32'h104, 32'hB104, 1'b0);
        checks++;
        if ({out_valid, in_ready, pc_out, instruction_out} !== {1'b1, 1'b0, 32'h100, 32'hB100}) begin
            errors++;
            $display("FAIL bp_full got ov=%0b ir=%0b pc=%h ins=%h want ov=1 ir=0 pc=100 ins=b100",
                     out_valid, in_ready, pc_out, instruction_out);
        end
        drive_cycle(1'b0, 1'b1, 32'h999, 32'hB999, 1'b0);
        checks++;
        if ({in_ready, pc_out, stall_cycles} !== {1'b0, 32'h100, 16'd2}) begin
            errors++;
            $display("FAIL bp_hold got ir=%0b pc=%h stall=%0d want ir=0 pc=100 stall=2",
                     in_ready, pc_out, stall_cycles);
        end
        drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if ({out_valid, in_ready, pc_out, instruction_out} !== {1'b1, 1'b1, 32'h104, 32'hB104}) begin
            errors++;
            $display("FAIL bp_second got ov=%0b ir=%0b pc=%h ins=%h want ov=1 ir=1 pc=104 ins=b104",
                     out_valid, in_ready, pc_out, instruction_out);
        end
        drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if ({out_valid, stall_cycles, stall_cycles4} !== {1'b0, 16'd2, 4'd2}) begin
            errors++;
            $display("FAIL bp_drain got ov=%0b stall=%0d/%0d want ov=0 stall=2/2",
                     out_valid, stall_cycles, stall_cycles4);
        end
    endtask

    task automatic test_flush();
        drive_cycle(1'b0, 1'b1, 32'h300, 32'hC300, 1'b0);
        drive_cycle(1'b0, 1'b1, 32'h304, 32'hC304, 1'b0);
        drive_cycle(1'b1, 1'b1, 32'h200, 32'hC200, 1'b0);
        checks++;
        if ({out_valid, in_ready, pc_out, instruction_out, stall_cycles} !==
            {1'b0, 1'b1, 32'h0, NOP, 16'd4}) begin
            errors++;
            $display("FAIL flush_full got ov=%0b ir=%0b pc=%h ins=%h stall=%0d want ov=0 ir=1 pc=0 ins=%h stall=4",
                     out_valid, in_ready, pc_out, instruction_out, stall_cycles, NOP);
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_noissue_%0d got ov=%0b pc=%h want ov=0", i, out_valid, pc_out);
            end
        end
        drive_cycle(1'b1, 1'b1, 32'h204, 32'hC204, 1'b1);
        checks++;
        if ({out_valid, pc_out, instruction_out} !== {1'b0, 32'h0, NOP}) begin
            errors++;
            $display("FAIL flush_empty got ov=%0b pc=%h ins=%h want ov=0 pc=0 ins=%h",
                     out_valid, pc_out, instruction_out, NOP);
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b0, 1'b1, 32'h500, 32'hD500, 1'b0);
        drive_cycle(1'b0, 1'b1, 32'h504, 32'hD504, 1'b0);
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL areset_setup got ov=%0b ir=%0b want ov=1 ir=0", out_valid, in_ready);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({out_valid, in_ready, pc_out, instruction_out, stall_cycles} !==
            {1'b0, 1'b1, 32'h0, NOP, 16'd0}) begin
            errors++;
            $display("FAIL areset_async got ov=%0b ir=%0b pc=%h ins=%h stall=%0d want ov=0 ir=1 pc=0 ins=%h stall=0",
                     out_valid, in_ready, pc_out, instruction_out, stall_cycles, NOP);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_saturation();
        drive_cycle(1'b0, 1'b1, 32'h400, 32'hE400, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            checks++;
            if (stall_cycles4 !== ((i > 15) ? 4'd15 : 4'(i)) || stall_cycles !== 16'(i)) begin
                errors++;
                $display("FAIL sat_%0d got %0d/%0d want %0d/%0d", i, stall_cycles4, stall_cycles,
                         (i > 15) ? 15 : i, i);
            end
        end
        drive_cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++;
        if ({stall_cycles, stall_cycles4, out_valid} !== {16'd21, 4'd15, 1'b0}) begin
            errors++;
            $display("FAIL sat_flush got %0d/%0d ov=%0b want 21/15 ov=0",
                     stall_cycles, stall_cycles4, out_valid);
        end
    endtask

    task automatic test_random();
        logic        prev_hold;
        logic [31:0] prev_pc;
        logic [31:0] prev_ins;
        logic        f;
        logic        iv;
        logic        ordy;
        logic [31:0] p;
        prev_hold = 1'b0;
        prev_pc   = '0;
        prev_ins  = '0;
        p         = 32'h1000;
        for (int i = 0; i < 2000; i++) begin
            f    = ($urandom_range(0, 99) < 5);
            iv   = ($urandom_range(0, 99) < 60);
            ordy = ($urandom_range(0, 99) < 50);
            prev_hold = out_valid && !ordy && !f;
            prev_pc   = pc_out;
            prev_ins  = instruction_out;
            drive_cycle(f, iv, p, $urandom, ordy);
            if (iv) p = p + 32'd4;
            checks++;
            if ({out_valid, in_ready, pc_out, instruction_out, stall_cycles} !==
                {mq.size() > 0, mq.size() < 2, m_pc, m_ins, m_cnt}) begin
                errors++;
                $display("FAIL rand_%0d got ov=%0b ir=%0b pc=%h ins=%h stall=%0d want ov=%0b ir=%0b pc=%h ins=%h stall=%0d",
                         i, out_valid, in_ready, pc_out, instruction_out, stall_cycles,
                         mq.size() > 0, mq.size() < 2, m_pc, m_ins, m_cnt);
            end
            if (prev_hold) begin
                checks++;
                if ({pc_out, instruction_out} !== {prev_pc, prev_ins}) begin
                    errors++;
                    $display("FAIL rand_stable_%0d got pc=%h ins=%h want pc=%h ins=%h",
                             i, pc_out, instruction_out, prev_pc, prev_ins);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifid_skid_stage.md
Name: ifid_skid_stage

Overview:
- Next-generation IF/ID pipeline stage that replaces the plain flushable register pair.
- Carries PC and instruction from fetch to decode with a valid/ready handshake on both sides.
- A 2-entry skid buffer lets decode stall without a combinational ready path back to fetch.
- Adds synchronous flush with NOP insertion, and a saturating stall-cycle counter for performance debug.

Parameters:
- len, 32, width of the PC and instruction datapaths.
- NOP_VALUE, 32'h00000000 (len bits), instruction value presented after reset or flush.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- flush  input  1  synchronous flush from the branch/hazard unit; active-high.
- in_valid  input  1  fetch presents a valid pc/instruction.
- in_ready  output  1  stage can accept; in_valid && in_ready = accept.
- pc  input  len  fetch PC.
- instruction  input  len  fetched instruction.
- out_valid  output  1  pc_out/instruction_out valid for decode.
- out_ready  input  1  decode consumes; out_valid && out_ready = issue.
- pc_out  output  len  registered PC to decode.
- instruction_out  output  len  registered instruction to decode.
- stall_cycles  output  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage:
  - main entry: drives the outputs, with main_valid = out_valid.
  - skid entry: pc, instruction, skid_valid.
- in_ready = !skid_valid. It is a register-derived value with no combinational path from out_ready.
- States, encoded by (main_valid, skid_valid):
  - EMPTY (0,0).
  - BUSY (1,0).
  - FULL (1,1).
  - (0,1) is unreachable.
- Transitions when flush=0:
  - EMPTY: accept -> main loads input -> BUSY; otherwise stay EMPTY.
  - BUSY, accept and issue: main loads input; stay BUSY.
  - BUSY, accept only: skid loads input -> FULL.
  - BUSY, issue only: -> EMPTY.
  - BUSY, neither: hold.
  - FULL: in_ready=0, so no accept.
    - On issue: main loads skid, skid_valid clears -> BUSY.
    - Otherwise hold.
- Latency: an accept in EMPTY or BUSY-with-issue appears on the outputs the next cycle (1 cycle).
- Ordering: strict FIFO. The skid entry is always older than any later input.
- Output stability: while out_valid && !out_ready, pc_out and instruction_out are held unchanged.
- When no load occurs, data registers retain their values; only the valid bits change.
- Flush has priority over every other event. At the next edge:
  - main_valid=0 and skid_valid=0 (-> EMPTY);
  - pc_out=0 and instruction_out=NOP_VALUE;
  - any input accepted in the flush cycle is discarded;
  - any issue in the flush cycle still counts as consumed by decode.
- Reset (reset=0, asynchronous):
  - out_valid=0, skid_valid=0, in_ready=1;
  - pc_out=0, instruction_out=NOP_VALUE, stall_cycles=0.
  - Reset mid-operation discards both entries immediately, without waiting for a clock edge.
  - Release is sampled synchronously at the next edge.
- stall_cycles:
  - increments by 1 on each edge where out_valid=1 and out_ready=0, including flush cycles;
  - saturates at all-ones;
  - cleared only by reset, not by flush.
- Simultaneous flush and in_valid in EMPTY: the input is dropped; out_valid stays 0.

Test Plan:
- Reset then stream, out_ready=1: accept pc 0x100/0x104/0x108 on consecutive cycles -> outputs appear 1 cycle later in order; out_valid held 1; in_ready stays 1; stall_cycles=0.
- Back-pressure: BUSY with pc 0x100; out_ready=0; accept pc 0x104 -> FULL, in_ready=0, pc_out holds 0x100. Then raise out_ready -> 0x100 issues, then 0x104; stall_cycles equals the number of stalled cycles.
- Flush from FULL with in_valid=1 (pc 0x200): next cycle out_valid=0, in_ready=1, instruction_out=NOP_VALUE, pc_out=0; neither 0x200 nor the buffered entries are ever issued.
- Async reset mid-FULL: drop reset between edges -> out_valid and in_ready go to their reset values (0 and 1) before the next clock edge; stall_cycles=0.
- Counter saturation with CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cycles reaches 15 and stays 15.
- Random valid/ready/flush regression: a scoreboard checks FIFO order, no loss except flushed entries, no duplication, and output stability under stall.
